fl_manager: RTL
===============

Name: fl_manager

Overview:
- Free-list manager for the shared packet buffer.
- Acts as the responder for the arbiter's serialized free-list allocation requests and for its block-free requests.
- Holds the indices of unallocated memory blocks in a circular FIFO, issues them in FIFO order, and returns freed blocks to the tail.
- Tracks the allocation state of every block, so it rejects illegal frees and never double-issues a block.

Parameters:
NUM_BLOCKS, 64, number of buffer blocks managed; indices 0..NUM_BLOCKS-1
ADDR_W, $clog2(NUM_BLOCKS), block index width; matches mem_pkg ADDR_W

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
fl_alloc_req_i  input  1  allocation request from arbiter; level, may change every cycle
fl_alloc_gnt_o  output  1  registered one-cycle grant pulse; one block issued per pulse
fl_alloc_block_idx_o  output  ADDR_W  issued block index; valid only while fl_alloc_gnt_o=1
free_req_i  input  1  free request, one block per cycle
free_block_idx_i  input  ADDR_W  block being freed
init_done_o  output  1  high once the FIFO is populated (READY state)
free_count_o  output  ADDR_W+1  number of blocks currently free
free_err_o  output  1  one-cycle pulse: a free was rejected

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. All state changes on posedge clk.
- Reset (any cycle, including mid-operation) clears all state:
  - Outputs: fl_alloc_gnt_o=0, fl_alloc_block_idx_o=0, init_done_o=0, free_count_o=0, free_err_o=0.
  - Internals: rd_ptr=0, wr_ptr=0, alloc bitmap all 0, FSM=INIT, init counter=0.
  - Outstanding grants are forgotten.
- FSM INIT:
  - Each cycle writes fifo[init_cnt]=init_cnt, increments init_cnt and free_count.
  - After writing NUM_BLOCKS-1, wr_ptr wraps to 0 and the FSM moves to READY.
  - INIT lasts exactly NUM_BLOCKS cycles. init_done_o rises on the following edge.
  - fl_alloc_gnt_o stays 0 throughout; requests are not queued.
  - Any free_req_i is dropped with a free_err_o pulse.
- FSM READY: stays until rst.
- Allocation (READY only):
  - Condition: at an edge where fl_alloc_req_i=1 and free_count_o!=0.
  - Actions on that edge: fl_alloc_gnt_o<=1, fl_alloc_block_idx_o<=fifo[rd_ptr], rd_ptr<=rd_ptr+1, bitmap[that idx]<=1.
  - Otherwise fl_alloc_gnt_o<=0; fl_alloc_block_idx_o holds its last value.
  - Latency is 1 cycle from a sampled request to the grant.
  - fl_alloc_gnt_o never depends combinationally on any input; this is required because the arbiter muxes its request using our grant.
  - Back-to-back grants are allowed: with a continuous request, one block per cycle.
  - Empty (free_count_o=0): no grant; request ignored that cycle.
- Free (READY only):
  - Accepted when free_req_i=1, free_block_idx_i<NUM_BLOCKS and bitmap[idx]=1.
  - Actions on accept: fifo[wr_ptr]<=idx, wr_ptr++, bitmap[idx]<=0.
  - Otherwise (out of range or not allocated, i.e. double free): no push; free_err_o<=1 for one cycle.
- Simultaneous alloc and free on the same edge:
  - Both occur; free_count_o is net unchanged.
  - A free arriving while empty is not grantable in the same edge. The grant comes on a later edge with the freed index.
- Arithmetic:
  - rd_ptr/wr_ptr are modulo NUM_BLOCKS (explicit wrap when NUM_BLOCKS is not a power of 2).
  - free_count_o ranges 0..NUM_BLOCKS; next = count + push - pop.
  - Overflow is impossible because bitmap checking rejects double frees.
- Invariant (assertion): free_count_o + popcount(bitmap) == NUM_BLOCKS in READY.

Test Plan:
- NUM_BLOCKS=8, rst high 2 cycles then low -> init_done_o=1 exactly 9 edges after rst falls; free_count_o=8; no grant during INIT even with fl_alloc_req_i held 1.
- Hold fl_alloc_req_i=1 for 10 cycles after READY -> 8 consecutive gnt pulses with idx 0,1,...,7; then gnt=0, free_count_o=0.
- After exhaustion, free idx 5 then idx 2, then request -> grants idx 5 then idx 2 (FIFO order); free_count_o returns to 0.
- Free idx 3 twice (allocated once); also free idx 3 when never allocated -> first free accepted; each illegal free gives one free_err_o pulse and free_count_o unchanged.
- Empty, same edge free idx 4 and req=1 -> no grant that edge; next edge gnt=1 with idx 4; free_count_o 0->1->0.
- Assert rst for 1 cycle mid-stream after 3 grants -> gnt=0 next edge, INIT re-runs, first post-reset grant is idx 0.

Source files
------------

// File: rtl/fl_manager.sv
// Free-list manager for the shared packet buffer: circular FIFO of free block
// indices with an allocation bitmap that rejects illegal frees.
module fl_manager #(
    parameter int unsigned NUM_BLOCKS = 64,
    parameter int unsigned ADDR_W     = $clog2(NUM_BLOCKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fl_alloc_req_i,
    output logic              fl_alloc_gnt_o,
    output logic [ADDR_W-1:0] fl_alloc_block_idx_o,
    input  logic              free_req_i,
    input  logic [ADDR_W-1:0] free_block_idx_i,
    output logic              init_done_o,
    output logic [ADDR_W:0]   free_count_o,
    output logic              free_err_o
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BLOCKS - 1);

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic [ADDR_W-1:0]     init_cnt;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W-1:0]     wr_ptr;
    logic [NUM_BLOCKS-1:0] bitmap;
    logic [ADDR_W-1:0]     fifo_mem [NUM_BLOCKS];

    logic                  pop;
    logic                  push;
    logic                  err;
    logic                  free_ok;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_waddr;
    logic [ADDR_W-1:0]     mem_wdata;
    logic [ADDR_W-1:0]     head_idx;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign head_idx = fifo_mem[rd_ptr];
    assign free_ok  = (CNT_W'(free_block_idx_i) < CNT_W'(NUM_BLOCKS)) && bitmap[free_block_idx_i];

    // Next-state and per-cycle push/pop/error decisions
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        push      = 1'b0;
        err       = 1'b0;
        case (state)
            ST_INIT: begin
                err = free_req_i;
                if (init_cnt == LAST_IDX) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                pop = fl_alloc_req_i && (free_count_o != '0);
                if (free_req_i) begin
                    if (free_ok) begin
                        push = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Single FIFO write port shared by initial population and frees
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_ptr;
        mem_wdata = free_block_idx_i;
        if (!rst) begin
            if (state == ST_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = init_cnt;
                mem_wdata = init_cnt;
            end else if (push) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            fifo_mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= ST_INIT;
            init_cnt             <= '0;
            rd_ptr               <= '0;
            wr_ptr               <= '0;
            bitmap               <= '0;
            fl_alloc_gnt_o       <= 1'b0;
            fl_alloc_block_idx_o <= '0;
            init_done_o          <= 1'b0;
            free_count_o         <= '0;
            free_err_o           <= 1'b0;
        end else begin
            state          <= state_nxt;
            init_done_o    <= (state == ST_READY);
            free_err_o     <= err;
            fl_alloc_gnt_o <= pop;

            if (state == ST_INIT) begin
                init_cnt     <= ptr_inc(init_cnt);
                free_count_o <= free_count_o + 1'b1;
            end else begin
                free_count_o <= free_count_o + CNT_W'(push) - CNT_W'(pop);
            end

            if (pop) begin
                fl_alloc_block_idx_o <= head_idx;
                rd_ptr               <= ptr_inc(rd_ptr);
                bitmap[head_idx]     <= 1'b1;
            end

            // A grantable block is never allocated, so push and pop never touch the same bit
            if (push) begin
                wr_ptr                   <= ptr_inc(wr_ptr);
                bitmap[free_block_idx_i] <= 1'b0;
            end
        end
    end

    // Every block is either in the free list or marked allocated
    always_ff @(posedge clk) begin
        if (!rst && state == ST_READY) begin
            assert ((32'(free_count_o) + 32'($countones(bitmap))) == 32'(NUM_BLOCKS));
        end
    end

endmodule
